// File: rtl/vault_lock_controller.sv
// Keypad vault lock: BCD digit entry, code check with consecutive-failure lockout,
// timed auto-relock and in-field code reprogramming while open.
module vault_lock_controller #(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned           MAX_FAIL       = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 1000,
  parameter int unsigned           OPEN_CYCLES    = 500
) (
  input  logic       clk,
  input  logic       RESETN,
  input  logic [3:0] DIGIT,
  input  logic       DIGIT_VALID,
  input  logic       ENTER,
  input  logic       CLEAR,
  input  logic       LOCK,
  input  logic       PROG,
  output logic       UNLOCKED,
  output logic       LOCKOUT,
  output logic       FAIL,
  output logic [1:0] ATTEMPTS,
  output logic [2:0] DIGIT_CNT,
  output logic [2:0] STATE
);

  localparam int unsigned EW  = 4 * CODE_LEN;
  localparam int unsigned OTW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam int unsigned LTW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0]     CNT_FULL   = 3'(CODE_LEN);
  localparam logic [2:0]     FAIL_LIMIT = 3'(MAX_FAIL);
  localparam logic [OTW-1:0] OPEN_LOAD  = OTW'(OPEN_CYCLES - 1);
  localparam logic [LTW-1:0] LOCK_LOAD  = LTW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_BLOCKED = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  entry_q, entry_d;
  logic [EW-1:0]  code_q, code_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [1:0]     attempts_q, attempts_d;
  logic [OTW-1:0] open_tmr_q, open_tmr_d;
  logic [LTW-1:0] lock_tmr_q, lock_tmr_d;
  logic           fail_q, fail_d;
  logic           unlocked_q, unlocked_d;
  logic           lockout_q, lockout_d;

  logic           digit_ok;
  logic           match;
  logic [2:0]     att_inc;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    attempts_d = attempts_q;
    open_tmr_d = open_tmr_q;
    lock_tmr_d = lock_tmr_q;
    fail_d     = 1'b0;

    digit_ok = DIGIT_VALID && (DIGIT <= 4'd9) && (cnt_q < CNT_FULL);
    match    = (cnt_q == CNT_FULL) && (entry_q == code_q);
    att_inc  = {1'b0, attempts_q} + 3'd1;

    case (state_q)
      S_LOCKED: begin
        // LOCK while already locked only swallows the other inputs of the cycle.
        if (!LOCK) begin
          if (CLEAR) begin
            entry_d = '0;
            cnt_d   = '0;
          end else if (ENTER) begin
            state_d = S_CHECK;
          end else if (digit_ok) begin
            entry_d = (entry_q << 4) | EW'(DIGIT);
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      S_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (match) begin
          state_d    = S_OPEN;
          attempts_d = '0;
          open_tmr_d = OPEN_LOAD;
        end else begin
          fail_d     = 1'b1;
          attempts_d = (att_inc >= FAIL_LIMIT) ? FAIL_LIMIT[1:0] : att_inc[1:0];
          if (att_inc >= FAIL_LIMIT) begin
            state_d    = S_BLOCKED;
            lock_tmr_d = LOCK_LOAD;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end

      S_OPEN: begin
        entry_d = '0;
        cnt_d   = '0;
        if (LOCK || (open_tmr_q == '0)) begin
          state_d = S_LOCKED;
        end else if (PROG) begin
          state_d = S_PROG;
        end else begin
          open_tmr_d = open_tmr_q - 1'b1;
        end
      end

      S_PROG: begin
        if (LOCK) begin
          state_d = S_LOCKED;
          entry_d = '0;
          cnt_d   = '0;
        end else if (CLEAR) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (ENTER) begin
          if (cnt_q == CNT_FULL) begin
            code_d = entry_q;
          end
          entry_d    = '0;
          cnt_d      = '0;
          state_d    = S_OPEN;
          open_tmr_d = OPEN_LOAD;
        end else if (digit_ok) begin
          entry_d = (entry_q << 4) | EW'(DIGIT);
          cnt_d   = cnt_q + 3'd1;
        end
      end

      S_BLOCKED: begin
        if (lock_tmr_q == '0) begin
          state_d    = S_LOCKED;
          attempts_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - 1'b1;
        end
      end

      default: begin
        state_d = S_LOCKED;
        entry_d = '0;
        cnt_d   = '0;
      end
    endcase

    unlocked_d = (state_d == S_OPEN) || (state_d == S_PROG);
    lockout_d  = (state_d == S_BLOCKED);
  end

  always_ff @(posedge clk) begin
    if (!RESETN) begin
      state_q    <= S_LOCKED;
      entry_q    <= '0;
      code_q     <= DEFAULT_CODE;
      cnt_q      <= '0;
      attempts_q <= '0;
      open_tmr_q <= '0;
      lock_tmr_q <= '0;
      fail_q     <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      attempts_q <= attempts_d;
      open_tmr_q <= open_tmr_d;
      lock_tmr_q <= lock_tmr_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
    end
  end

  assign STATE     = state_q;
  assign UNLOCKED  = unlocked_q;
  assign LOCKOUT   = lockout_q;
  assign FAIL      = fail_q;
  assign ATTEMPTS  = attempts_q;
  assign DIGIT_CNT = cnt_q;

endmodule

// File: doc/vault_lock_controller.md
VAULT_LOCK_CONTROLLER -- requirements
Module: vault_lock_controller

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning digits per code (1..7).
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the reset code as BCD nibbles, first digit in the most-significant nibble, width 4*CODE_LEN.
REQ-003 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive mismatches that triggers lockout (1..3).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000, meaning the lockout duration in clk cycles (>=1).
REQ-005 SHALL have parameter OPEN_CYCLES, default 500, meaning the auto-relock time in clk cycles (>=1).
REQ-006 SHALL have port clk, input, 1 bit: the clock, rising edge.
REQ-007 SHALL have port RESETN, input, 1 bit: synchronous active-low reset.
REQ-008 SHALL have port DIGIT, input, 4 bits: BCD keypad digit.
REQ-009 SHALL have port DIGIT_VALID, input, 1 bit: DIGIT qualifier, one-cycle pulse.
REQ-010 SHALL have port ENTER, input, 1 bit: submit the entry.
REQ-011 SHALL have port CLEAR, input, 1 bit: discard the entry.
REQ-012 SHALL have port LOCK, input, 1 bit: relock request.
REQ-013 SHALL have port PROG, input, 1 bit: enter code-change mode.
REQ-014 SHALL have port UNLOCKED, output, 1 bit: vault open.
REQ-015 SHALL have port LOCKOUT, output, 1 bit: keypad disabled.
REQ-016 SHALL have port FAIL, output, 1 bit: one-cycle mismatch pulse.
REQ-017 SHALL have port ATTEMPTS, output, 2 bits: consecutive failure count.
REQ-018 SHALL have port DIGIT_CNT, output, 3 bits: digits held in the entry register.
REQ-019 SHALL have port STATE, output, 3 bits: state encoding LOCKED=0, CHECK=1, OPEN=2, PROG=3, BLOCKED=4.

Function
REQ-020 SHALL accept a digit only in LOCKED or PROG, when DIGIT_VALID=1, DIGIT<=9 and DIGIT_CNT<CODE_LEN: the entry shifts left one nibble, DIGIT loads the LSB nibble, and DIGIT_CNT increments.
REQ-021 SHALL ignore a DIGIT_VALID that carries DIGIT>9 or arrives when DIGIT_CNT==CODE_LEN; the entry and count are then unchanged, with no wrap.
REQ-022 SHALL give same-cycle input priority in LOCKED and PROG as LOCK > CLEAR > ENTER > DIGIT_VALID, with lower-priority inputs in that cycle discarded.
REQ-023 SHALL, on CLEAR in LOCKED or PROG, zero the entry and DIGIT_CNT while the state is unchanged.
REQ-024 SHALL, on ENTER in LOCKED, move to CHECK on the next clock at any DIGIT_CNT.
REQ-025 SHALL remain in CHECK exactly one cycle, with match = (DIGIT_CNT==CODE_LEN) and (entry==code).
REQ-026 SHALL, on a CHECK match, move to OPEN, zero ATTEMPTS, and load the open timer with OPEN_CYCLES-1.
REQ-027 SHALL, on a CHECK mismatch, assert FAIL for the CHECK-exit cycle, registered so FAIL is high in the cycle after CHECK, and increment ATTEMPTS.
REQ-028 SHALL, on a CHECK mismatch where ATTEMPTS+1 reaches MAX_FAIL, move to BLOCKED and load the lockout counter with LOCKOUT_CYCLES-1; otherwise it SHALL move to LOCKED.
REQ-029 SHALL zero the entry and DIGIT_CNT on every exit from CHECK.
REQ-030 SHALL set the latency as: ENTER sampled at edge N gives STATE=CHECK after N, and UNLOCKED=1 or FAIL=1 after N+1.
REQ-031 SHALL, in OPEN, decrement the open timer each cycle and move to LOCKED when LOCK=1 or the timer is 0.
REQ-032 SHALL, in OPEN with PROG=1 and LOCK=0, move to PROG with the entry cleared and the open timer frozen.
REQ-033 SHALL, on ENTER in PROG with DIGIT_CNT==CODE_LEN, load the code register from the entry, clear the entry, and return to OPEN with the timer reloaded.
REQ-034 SHALL, on ENTER in PROG with DIGIT_CNT<CODE_LEN, leave the code unchanged and return to OPEN with the timer reloaded; on LOCK in PROG it SHALL move to LOCKED with the code unchanged.
REQ-035 SHALL, in BLOCKED, ignore all inputs except RESETN, decrement the lockout counter, and at 0 move to LOCKED with ATTEMPTS zeroed.
REQ-036 SHALL decode UNLOCKED=1 iff STATE is OPEN or PROG, and LOCKOUT=1 iff STATE is BLOCKED.
REQ-037 SHALL saturate ATTEMPTS at MAX_FAIL and never wrap it.

Reset
REQ-038 SHALL, while RESETN=0 at a clk edge, force STATE=LOCKED, code=DEFAULT_CODE, entry=0, DIGIT_CNT=0, ATTEMPTS=0, timers=0, UNLOCKED=0, LOCKOUT=0, FAIL=0.
REQ-039 SHALL let reset override every state, including BLOCKED and PROG, and SHALL restore DEFAULT_CODE, discarding any programmed code.

Verification
REQ-040 SHALL cover correct code: digits 1,2,3,4 then ENTER -> STATE 1 then 2, UNLOCKED=1 two cycles after ENTER, ATTEMPTS=0.
REQ-041 SHALL cover lockout: three entries of 1,2,3,5+ENTER -> FAIL pulses 3 times, ATTEMPTS 1,2,3, STATE=4, LOCKOUT=1 for exactly 1000 cycles, then STATE=0 and ATTEMPTS=0.
REQ-042 SHALL cover entry boundaries: 1,2,3,4,9 with DIGIT 4'hA inserted -> DIGIT_CNT stops at 4, entry 16'h1234, 'A' ignored; a short entry 1,2,3+ENTER -> FAIL.
REQ-043 SHALL cover programming: unlock, PROG, 9,8,7,6, ENTER, LOCK, then 9,8,7,6+ENTER -> unlock; 1,2,3,4+ENTER -> FAIL.
REQ-044 SHALL cover same-cycle inputs: LOCK+PROG together in OPEN -> LOCKED; CLEAR+ENTER together in LOCKED -> DIGIT_CNT=0 and STATE stays 0.
REQ-045 SHALL cover reset and auto-relock: RESETN=0 mid-BLOCKED -> LOCKED with code 1234 next cycle; OPEN with no input -> LOCKED after 500 cycles.
